dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
Data-memory responder at the far end of the CPU load/store interface. It accepts one load or store request at a time, carrying a byte address, a DMType code and write data, over a valid/ready handshake. It performs the access on an internal word-wide, word-addressed RAM that has no byte enables, so sub-word stores are done as read-modify-write. It returns sign- or zero-extended load data, or an error flag, over a valid/ready response channel.

Parameters:
DEPTH_WORDS, 128, number of 32-bit RAM words; power of two, at least 2.
IDX_W, $clog2(DEPTH_WORDS), word-index width; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rstn  in  1  synchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_addr  in  32  byte address, little-endian.
req_dmtype  in  3  access type: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
req_wdata  in  32  store data, taken from the low bits for sub-word stores.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer takes the response.
rsp_rdata  out  32  extended load data; 0 for stores and errors.
rsp_err  out  1  request was rejected; no memory side effect.

Behaviour:
- Reset: synchronous, active-low, highest priority.
  - On the reset edge: state goes to IDLE; rsp_valid, rsp_err and rsp_rdata become 0; req_ready becomes 1 on the first cycle after reset.
  - RAM contents are not cleared.
  - A write pending in the reset cycle does not commit.
- Accept: a request is accepted on a rising edge with req_valid & req_ready.
  - On that edge, addr, dmtype, we and wdata are latched.
  - Inputs are ignored outside IDLE.
- Index: idx = addr[IDX_W+1:2]. The address is out of range if addr[31:IDX_W+2] != 0.
- Error check, evaluated at accept:
  - misaligned word: dmtype 000 with addr[1:0] != 0.
  - misaligned half: dmtype 001/010 with addr[0] = 1.
  - out of range.
  - dmtype 101..111.
  - store with dmtype 010 or 100.
  - An error goes IDLE -> RSP with rsp_err=1 and rsp_rdata=0. No RAM read or write takes place.
- States: IDLE, RD, WR, MOD, RSP.
  - IDLE -> RSP on an error.
  - IDLE -> WR on a word store.
  - IDLE -> RD on a load or a sub-word store.
  - RD: RAM word registered into rd_word at the end of the cycle. Next state is RSP for a load, MOD for a sub-word store.
  - WR: mem[idx] <= wdata. Next state RSP.
  - MOD: mem[idx] <= merged word. Next state RSP.
    - byte merge: lane addr[1:0] replaced with wdata[7:0].
    - half merge: lanes {addr[1],0} and {addr[1],1} replaced with wdata[15:0].
  - RSP: rsp_valid=1. Go to IDLE on rsp_ready; otherwise hold.
- Latency, counted from the accept edge to the first cycle with rsp_valid high:
  - error: 1 cycle.
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
- Load data, computed from rd_word and registered on entry to RSP:
  - word: rd_word as is.
  - half: rd_word[16*addr[1] +: 16], sign-extended for 001, zero-extended for 010.
  - byte: rd_word[8*addr[1:0] +: 8], sign-extended for 011, zero-extended for 100.
- Response hold: while rsp_valid=1 and rsp_ready=0, rsp_rdata and rsp_err stay stable. rsp_valid drops on the cycle after the handshake edge.
- Throughput: at most one request in flight. A new request can be accepted no earlier than the cycle after the response handshake.

Test Plan:
- Word round trip: store word (dmtype 000) 0xDEADBEEF at 0x10; load word from 0x10 -> rsp_rdata=0xDEADBEEF, err=0. Store response 2 cycles after accept; load response 2 cycles after accept.
- Byte store and loads: store byte (011) wdata 0x000000AA at 0x11 -> response 3 cycles after accept. Then word load from 0x10 -> 0xDEADAAEF; byte load (011) from 0x11 -> 0xFFFFFFAA; byte-unsigned load (100) from 0x11 -> 0x000000AA.
- Half store and loads: store half (001) 0x1234 at 0x12 -> word load from 0x10 gives 0x1234AAEF. Half load (001) from 0x10 -> 0xFFFFAAEF; half-unsigned load (010) from 0x10 -> 0x0000AAEF; half load (001) from 0x12 -> 0x00001234.
- Errors, each with rsp_err=1, rsp_rdata=0, latency 1 and no memory change (checked by a later word load from 0x10 returning 0x1234AAEF):
  - word load from 0x13.
  - half store (001) to 0x11.
  - word load from 0x200 with DEPTH_WORDS=128.
  - dmtype 101.
  - store with dmtype 100.
- Backpressure: hold rsp_ready=0 for 5 cycles after the load response appears -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0. A concurrent req_valid is not accepted. Raise rsp_ready -> IDLE on the next cycle and req_ready=1.
- Reset mid-operation: pull rstn low during the MOD cycle of a byte store of 0x55 to 0x10 -> next cycle IDLE, rsp_valid=0. A subsequent word load from 0x10 still returns 0x1234AAEF.

Source files
------------

// File: rtl/dm_responder_if.sv
// rtl/dm_responder_if.sv - load/store request and response channels between CPU and data memory
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_dmtype;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_dmtype, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_dmtype, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder with read-modify-write sub-word stores
module dm_responder #(
    parameter  int DEPTH_WORDS = 128,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rstn,
    dm_responder_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_MOD, S_RSP} state_t;

    state_t state, state_nxt;

    logic             req_ready_c, rsp_valid_c;
    logic             accept, req_err, store_word;
    logic             we_q;
    logic [2:0]       dt_q;
    logic [1:0]       lane_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rd_raw, rd_word, load_ext, merged;
    logic [15:0]      half_sel;
    logic [7:0]       byte_sel;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;
    logic [31:0]      mem [DEPTH_WORDS];

    assign accept     = bus.req_valid && req_ready_c;
    assign store_word = bus.req_we && (bus.req_dmtype == 3'd0);

    always_comb begin
        req_err = 1'b0;
        case (bus.req_dmtype)
            3'd0:       if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
            3'd1, 3'd2: if (bus.req_addr[0]) req_err = 1'b1;
            3'd3, 3'd4: ;
            default:    req_err = 1'b1;
        endcase
        if (bus.req_addr[31:IDX_W+2] != '0) req_err = 1'b1;
        if (bus.req_we && (bus.req_dmtype == 3'd2 || bus.req_dmtype == 3'd4)) req_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.req_valid) begin
                if (req_err)         state_nxt = S_RSP;
                else if (store_word) state_nxt = S_WR;
                else                 state_nxt = S_RD;
            end
            S_RD:    state_nxt = we_q ? S_MOD : S_RSP;
            S_WR:    state_nxt = S_RSP;
            S_MOD:   state_nxt = S_RSP;
            S_RSP:   if (bus.rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_c = (state == S_IDLE);
        rsp_valid_c = (state == S_RSP);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            dt_q    <= 3'd0;
            lane_q  <= 2'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            dt_q    <= bus.req_dmtype;
            lane_q  <= bus.req_addr[1:0];
            idx_q   <= bus.req_addr[IDX_W+1:2];
            wdata_q <= bus.req_wdata;
        end
    end

    assign rd_raw = mem[idx_q];

    always_ff @(posedge clk) begin
        if (state == S_RD) rd_word <= rd_raw;
    end

    // Load extension works on the raw RAM output so the result lands together with rd_word.
    always_comb begin
        half_sel = lane_q[1] ? rd_raw[31:16] : rd_raw[15:0];
        byte_sel = rd_raw[8*lane_q +: 8];
        case (dt_q)
            3'd0:    load_ext = rd_raw;
            3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
            3'd2:    load_ext = {16'd0, half_sel};
            3'd3:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'd4:    load_ext = {24'd0, byte_sel};
            default: load_ext = 32'd0;
        endcase
    end

    always_comb begin
        merged = rd_word;
        if (dt_q == 3'd3) merged[8*lane_q +: 8]      = wdata_q[7:0];
        else              merged[16*lane_q[1] +: 16] = wdata_q[15:0];
    end

    // Gated on rstn so a write scheduled in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (state == S_WR)       mem[idx_q] <= wdata_q;
            else if (state == S_MOD) mem[idx_q] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= req_err;
        end else if (state == S_RD && !we_q) begin
            rsp_rdata_q <= load_ext;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed and random load/store checks against a byte-array memory model
module tb_dm_responder;
    localparam int DEPTH = 128;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dm_responder_if bus();

    dm_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] ref_mem [DEPTH*4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic we, input logic [31:0] addr, input logic [2:0] dt,
                                  input logic [31:0] wd, output logic err, output logic [31:0] rd,
                                  output int lat);
        int size;
        int base;
        logic [31:0] v;
        size = (dt == 3'd0) ? 4 : ((dt == 3'd1 || dt == 3'd2) ? 2 : 1);
        err = (dt > 3'd4) || (addr >= 32'(DEPTH*4)) || ((addr & 32'(size-1)) != 32'd0)
              || (we && (dt == 3'd2 || dt == 3'd4));
        rd = 32'd0;
        lat = 1;
        if (!err) begin
            base = int'(addr);
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[base+i] = wd[8*i +: 8];
                lat = (size == 4) ? 2 : 3;
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
                if ((dt == 3'd1 || dt == 3'd3) && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                rd = v;
                lat = 2;
            end
        end
    endfunction

    task automatic send(input logic we, input logic [31:0] addr, input logic [2:0] dt, input logic [31:0] wd);
        @(negedge clk);
        chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_dmtype = dt;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        bit got = 0;
        lat = 0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) got = 1;
        end
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [2:0] dt,
                           input logic [31:0] wd, input string tag, output logic [31:0] obs);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat, lat;
        model(we, addr, dt, wd, e_err, e_rd, e_lat);
        send(we, addr, dt, wd);
        wait_rsp(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
        chk({tag, "_rdata"}, bus.rsp_rdata, e_rd);
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(e_err));
        obs = bus.rsp_rdata;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    logic [31:0] r;
    int          lat;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_dmtype = 3'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) run_txn(1'b1, 32'(i*4), 3'd0, $urandom, "init_store", r);

        run_txn(1'b1, 32'h10, 3'd0, 32'hDEADBEEF, "store_word", r);
        run_txn(1'b0, 32'h10, 3'd0, 32'd0, "load_word", r);
        chk("word_round_trip", r, 32'hDEADBEEF);

        run_txn(1'b1, 32'h11, 3'd3, 32'h000000AA, "store_byte", r);
        run_txn(1'b0, 32'h10, 3'd0, 32'd0, "load_after_byte", r);
        chk("word_after_byte", r, 32'hDEADAAEF);
        run_txn(1'b0, 32'h11, 3'd3, 32'd0, "load_byte_s", r);
        chk("byte_signed", r, 32'hFFFFFFAA);
        run_txn(1'b0, 32'h11, 3'd4, 32'd0, "load_byte_u", r);
        chk("byte_unsigned", r, 32'h000000AA);

        run_txn(1'b1, 32'h12, 3'd1, 32'h00001234, "store_half", r);
        run_txn(1'b0, 32'h10, 3'd0, 32'd0, "load_after_half", r);
        chk("word_after_half", r, 32'h1234AAEF);
        run_txn(1'b0, 32'h10, 3'd1, 32'd0, "load_half_s_lo", r);
        chk("half_signed_lo", r, 32'hFFFFAAEF);
        run_txn(1'b0, 32'h10, 3'd2, 32'd0, "load_half_u_lo", r);
        chk("half_unsigned_lo", r, 32'h0000AAEF);
        run_txn(1'b0, 32'h12, 3'd1, 32'd0, "load_half_s_hi", r);
        chk("half_signed_hi", r, 32'h00001234);

        run_txn(1'b0, 32'h13, 3'd0, 32'd0, "err_misaligned_word", r);
        run_txn(1'b1, 32'h11, 3'd1, 32'hFFFFFFFF, "err_misaligned_half", r);
        run_txn(1'b0, 32'h200, 3'd0, 32'd0, "err_out_of_range", r);
        run_txn(1'b0, 32'h10, 3'd5, 32'd0, "err_bad_dmtype", r);
        run_txn(1'b1, 32'h10, 3'd4, 32'hFFFFFFFF, "err_unsigned_store", r);
        run_txn(1'b0, 32'h10, 3'd0, 32'd0, "load_after_errors", r);
        chk("no_side_effect_errors", r, 32'h1234AAEF);

        send(1'b0, 32'h10, 3'd0, 32'd0);
        wait_rsp(lat);
        chk("bp_latency", 32'(lat), 32'd2);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_addr   = 32'h10;
        bus.req_dmtype = 3'd0;
        bus.req_wdata  = 32'h0BADF00D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", bus.rsp_rdata, 32'h1234AAEF);
            chk("bp_rsp_err", 32'(bus.rsp_err), 32'd0);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
        run_txn(1'b0, 32'h10, 3'd0, 32'd0, "load_after_bp", r);
        chk("bp_store_not_taken", r, 32'h1234AAEF);

        send(1'b1, 32'h10, 3'd3, 32'h00000055);
        @(negedge clk);
        chk("rst_mid_rd_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        run_txn(1'b0, 32'h10, 3'd0, 32'd0, "load_after_reset", r);
        chk("reset_blocks_write", r, 32'h1234AAEF);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else                           a = 32'($urandom_range(0, 63));
            run_txn(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 5)), $urandom, "random", r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
